// File: rtl/omer_pkg.sv
// Shared types and constants for the kamus instruction fetch unit.
//   fetch_entry_t  : one prefetch FIFO entry {pc, instr, fault}
//   fetch_state_e  : fetch FSM states
//   KAMUS_RESET_PC : default PC fetched first after reset
package omer_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] KAMUS_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FS_RUN   = 1'b0,
        FS_FAULT = 1'b1
    } fetch_state_e;

    // Clear the byte offset so a fetch address is always word aligned.
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/kamus_fetch_fifo.sv
// In-order synchronous FIFO of fetch entries.
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_push, i_wdata    : write an entry (ignored when full without a pop)
//   i_pop              : remove the head entry (ignored when empty)
//   i_flush            : empty the FIFO; wins over push and pop
//   o_head             : current head entry
//   o_full, o_empty    : occupancy flags
//   o_count            : number of stored entries
module kamus_fetch_fifo
    import omer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  fetch_entry_t                 i_wdata,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output fetch_entry_t                 o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Push is allowed when full only if the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Pointer and count update; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage write.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush && !i_rst) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/kamus_if.sv
// Instruction fetch unit for the kamus RV32I core.
// Issues word fetches on a req/gnt/rvalid memory port, buffers returned words
// in an in-order prefetch FIFO and hands them to the decoder with valid/ready.
// Ports:
//   clk_i, rst_i                   : clock, synchronous active-high reset
//   imem_req_o, imem_addr_o        : fetch request and word-aligned address
//   imem_gnt_i                     : request accepted this cycle
//   imem_rvalid_i, imem_rdata_i    : in-order read response
//   redirect_i, redirect_pc_i      : flush and restart fetching at a new PC
//   instr_valid_o, instr_ready_i   : decoder handshake
//   instr_o, instr_pc_o            : instruction word and its PC
//   instr_fault_o                  : entry is a misaligned-fetch fault
module kamus_if
    import omer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = KAMUS_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_fault_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        w_fetch_pc_nxt;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   w_outstanding_nxt;
    logic [CNT_W-1:0]   r_discard;
    logic [CNT_W-1:0]   w_discard_nxt;
    logic [31:0]        r_pc_of_head;
    logic [31:0]        w_pc_of_head_nxt;
    logic [31:0]        r_fault_pc;
    logic [31:0]        w_fault_pc_nxt;
    logic               r_fault_pending;
    logic               w_fault_pending_nxt;

    fetch_entry_t       w_head;
    fetch_entry_t       w_wdata;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_fifo_count;

    logic               w_credit;
    logic               w_grant;
    logic               w_resp;
    logic               w_drop;
    logic               w_push_data;
    logic               w_push_fault;
    logic               w_push;
    logic               w_pop;

    // Only request when every in-flight response is guaranteed a FIFO slot.
    assign w_credit = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < SUM_W'(FIFO_DEPTH);

    assign imem_req_o  = !rst_i && (r_state == FS_RUN) && !redirect_i && w_credit;
    assign imem_addr_o = r_fetch_pc;

    assign w_grant      = imem_req_o && imem_gnt_i;
    // Responses with nothing in flight are stale (pre-reset) and ignored.
    assign w_resp       = imem_rvalid_i && (r_outstanding != '0);
    assign w_drop       = w_resp && (r_discard != '0);
    assign w_push_data  = w_resp && !w_drop && (r_state == FS_RUN);
    assign w_push_fault = (r_state == FS_FAULT) && r_fault_pending && w_fifo_empty;
    assign w_push       = !redirect_i && (w_push_data || w_push_fault)
                          && (!w_fifo_full || w_pop);
    assign w_pop        = instr_valid_o && instr_ready_i && !redirect_i;

    always_comb begin
        w_wdata = '0;
        if (w_push_fault) begin
            w_wdata.pc    = r_fault_pc;
            w_wdata.instr = '0;
            w_wdata.fault = 1'b1;
        end else begin
            w_wdata.pc    = r_pc_of_head;
            w_wdata.instr = imem_rdata_i;
            w_wdata.fault = 1'b0;
        end
    end

    kamus_fetch_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign instr_valid_o = !w_fifo_empty;
    assign instr_o       = instr_valid_o ? w_head.instr : '0;
    assign instr_pc_o    = instr_valid_o ? w_head.pc    : '0;
    assign instr_fault_o = instr_valid_o && w_head.fault;

    // Next-state and fetch bookkeeping; a redirect overrides everything else.
    always_comb begin
        w_state_nxt         = r_state;
        w_fetch_pc_nxt      = r_fetch_pc;
        w_outstanding_nxt   = r_outstanding + CNT_W'(w_grant) - CNT_W'(w_resp);
        w_discard_nxt       = r_discard;
        w_pc_of_head_nxt    = r_pc_of_head;
        w_fault_pc_nxt      = r_fault_pc;
        w_fault_pending_nxt = r_fault_pending;

        if (redirect_i) begin
            // Everything still in flight after this cycle belongs to the old stream.
            w_discard_nxt    = w_outstanding_nxt;
            w_fetch_pc_nxt   = pc_align(redirect_pc_i);
            w_pc_of_head_nxt = pc_align(redirect_pc_i);
            if (redirect_pc_i[1:0] != 2'b00) begin
                w_state_nxt         = FS_FAULT;
                w_fault_pc_nxt      = redirect_pc_i;
                w_fault_pending_nxt = 1'b1;
            end else begin
                w_state_nxt         = FS_RUN;
                w_fault_pending_nxt = 1'b0;
            end
        end else begin
            if (w_grant) begin
                w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            end
            if (w_drop) begin
                w_discard_nxt = r_discard - CNT_W'(1);
            end
            if (w_push_data && w_push) begin
                w_pc_of_head_nxt = r_pc_of_head + 32'd4;
            end
            if (w_push_fault && w_push) begin
                w_fault_pending_nxt = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= FS_RUN;
            r_fetch_pc      <= RESET_PC;
            r_outstanding   <= '0;
            r_discard       <= '0;
            r_pc_of_head    <= RESET_PC;
            r_fault_pc      <= '0;
            r_fault_pending <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_fetch_pc      <= w_fetch_pc_nxt;
            r_outstanding   <= w_outstanding_nxt;
            r_discard       <= w_discard_nxt;
            r_pc_of_head    <= w_pc_of_head_nxt;
            r_fault_pc      <= w_fault_pc_nxt;
            r_fault_pending <= w_fault_pending_nxt;
        end
    end

endmodule

// File: tb/tb_kamus_if.sv
// Directed testbench for kamus_if with a one-cycle-latency instruction memory.
module tb_kamus_if;
    import omer_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_fault_o;

    always #5 clk_i = ~clk_i;

    kamus_if dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_fault_o (instr_fault_o)
    );

    typedef struct {
        logic        do_redir;
        logic [31:0] rpc;
        logic [31:0] exp_pc;
        logic        exp_fault;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          n_grants = 0;
    bit          resp_en = 1'b1;
    logic [31:0] q[$];
    vec_t        vecs[13];

    logic        s_req, s_valid, s_fault, s_accept;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: sample at the falling edge, memory responds after the rising edge.
    task automatic tick();
        @(negedge clk_i);
        s_req    = imem_req_o;
        s_addr   = imem_addr_o;
        s_valid  = instr_valid_o;
        s_pc     = instr_pc_o;
        s_instr  = instr_o;
        s_fault  = instr_fault_o;
        s_accept = instr_valid_o && instr_ready_i && !redirect_i;
        if (imem_req_o && imem_gnt_i) begin
            q.push_back(imem_addr_o);
            n_grants++;
        end
        @(posedge clk_i);
        #1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        if (rst_i) begin
            q.delete();
        end else if (resp_en && q.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(q.pop_front());
        end
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        redirect_i = 1'b0;
        resp_en    = 1'b1;
        tick();
        tick();
        rst_i    = 1'b0;
        n_grants = 0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        tick();
        chk("redirect_no_req", 32'(s_req), 32'h0);
        redirect_i = 1'b0;
    endtask

    // Wait (bounded) for the next accepted entry and compare it.
    task automatic expect_entry(input logic [31:0] pc, input logic fault, input string name);
        bit got = 1'b0;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (s_accept) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no entry expected pc 0x%08h", name, pc);
        end else begin
            chk({name, "_pc"}, s_pc, pc);
            chk({name, "_instr"}, s_instr, fault ? 32'h0 : mem_word(pc));
            chk({name, "_fault"}, 32'(s_fault), 32'(fault));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h0,         32'h0000_0004, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,         32'h0000_0008, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,         32'h0000_000C, 1'b0};
        vecs[3]  = '{1'b1, 32'h100,       32'h0000_0100, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,         32'h0000_0104, 1'b0};
        vecs[5]  = '{1'b1, 32'h102,       32'h0000_0102, 1'b1};
        vecs[6]  = '{1'b1, 32'h200,       32'h0000_0200, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,         32'h0000_0204, 1'b0};
        vecs[8]  = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h0,         32'h0000_0004, 1'b0};
        vecs[11] = '{1'b1, 32'h40,        32'h0000_0040, 1'b0};
        vecs[12] = '{1'b0, 32'h0,         32'h0000_0044, 1'b0};

        rst_i         = 1'b1;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;

        // Reset values.
        do_reset();
        chk("reset_req",   32'(s_req),   32'h0);
        chk("reset_addr",  s_addr,       32'h0);
        chk("reset_valid", 32'(s_valid), 32'h0);
        chk("reset_instr", s_instr,      32'h0);
        chk("reset_pc",    s_pc,         32'h0);
        chk("reset_fault", 32'(s_fault), 32'h0);

        // First fetch latency: grant c0, rvalid c1, visible c2.
        instr_ready_i = 1'b1;
        tick();
        chk("c0_req",   32'(s_req),   32'h1);
        chk("c0_addr",  s_addr,       32'h0);
        chk("c0_valid", 32'(s_valid), 32'h0);
        tick();
        chk("c1_addr",  s_addr,       32'h4);
        chk("c1_valid", 32'(s_valid), 32'h0);
        tick();
        chk("c2_valid", 32'(s_valid), 32'h1);
        chk("c2_pc",    s_pc,         32'h0);
        chk("c2_instr", s_instr,      mem_word(32'h0));

        // Streaming, redirects, fault entry and PC wrap.
        foreach (vecs[i]) begin
            if (vecs[i].do_redir) redirect(vecs[i].rpc);
            expect_entry(vecs[i].exp_pc, vecs[i].exp_fault, $sformatf("vec%0d", i));
        end

        // Back-pressure from an empty pipeline: exactly FIFO_DEPTH grants.
        do_reset();
        instr_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("bp_grants", 32'(n_grants), 32'd2);
        chk("bp_req",    32'(s_req),    32'h0);
        chk("bp_valid",  32'(s_valid),  32'h1);
        chk("bp_pc",     s_pc,          32'h0);
        expect_entry(32'h0, 1'b0, "bp0");
        expect_entry(32'h4, 1'b0, "bp1");
        expect_entry(32'h8, 1'b0, "bp2");

        // Redirect with two held responses outstanding: both are discarded.
        do_reset();
        resp_en       = 1'b0;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("hold_grants", 32'(n_grants), 32'd2);
        chk("hold_req",    32'(s_req),    32'h0);
        resp_en = 1'b1;
        redirect(32'h100);
        expect_entry(32'h100, 1'b0, "rd0");
        expect_entry(32'h104, 1'b0, "rd1");

        // Redirect in the same cycle as a response (grant asserted by memory).
        do_reset();
        resp_en       = 1'b0;
        instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        resp_en = 1'b1;
        tick();
        chk("rv_same_cycle", 32'(imem_rvalid_i), 32'h1);
        redirect(32'h300);
        expect_entry(32'h300, 1'b0, "rv0");
        expect_entry(32'h304, 1'b0, "rv1");

        // Back-to-back redirects: the last one wins.
        redirect(32'h500);
        redirect(32'h600);
        expect_entry(32'h600, 1'b0, "b2b0");
        expect_entry(32'h604, 1'b0, "b2b1");

        // Misaligned redirect: no requests, single fault entry, held until redirect.
        redirect(32'h0000_0006);
        instr_ready_i = 1'b0;
        n_grants = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("flt_grants", 32'(n_grants), 32'd0);
        chk("flt_valid",  32'(s_valid),  32'h1);
        chk("flt_pc",     s_pc,          32'h6);
        chk("flt_instr",  s_instr,       32'h0);
        chk("flt_flag",   32'(s_fault),  32'h1);
        instr_ready_i = 1'b1;
        tick();
        chk("flt_accept", 32'(s_accept), 32'h1);
        for (int i = 0; i < 4; i++) tick();
        chk("flt_empty_after", 32'(s_valid), 32'h0);
        chk("flt_no_grants",   32'(n_grants), 32'd0);
        redirect(32'h200);
        expect_entry(32'h200, 1'b0, "flt_resume");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
